// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the TinyALU command sequencer family: the ALU opcode
// encoding, the sequencer state encoding and a helper that tells whether an
// opcode is one the ALU understands.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_AND = 3'd2,
        OP_XOR = 3'd3,
        OP_MUL = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_e;

    // Opcodes 5..7 have no ALU meaning and are answered with an error response
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op <= 3'(OP_MUL));
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous first-word-fall-through FIFO used to buffer ALU commands.
// Ports:
//   clk_i        - clock, rising edge
//   reset_i      - synchronous active-low reset (flushes the FIFO)
//   push_i       - write push_data_i (ignored when full)
//   push_data_i  - entry to write
//   pop_i        - drop the head entry (ignored when empty)
//   pop_data_o   - current head entry
//   full_o       - DEPTH entries stored
//   empty_o      - no entries stored
//   count_o      - number of stored entries
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        push_ok  = push_i && !full_o;
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Buffers ALU commands, drives the TinyALU start/op/A/B pin protocol, waits
// for done with a timeout and returns results on a valid/ready stream.
// Ports:
//   clk_i, reset_i              - clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o     - command handshake (ready = FIFO not full)
//   cmd_op_i, cmd_a_i, cmd_b_i  - command opcode and operands
//   alu_start_o, alu_op_o,
//   alu_a_o, alu_b_o            - ALU BFM drive pins
//   alu_done_i, alu_result_i    - ALU completion pins
//   rsp_valid_o/rsp_ready_i     - response handshake
//   rsp_op_o, rsp_result_o,
//   rsp_err_o                   - response payload (err = timeout / illegal op)
//   issued_cnt_o                - commands driven to the ALU (wraps)
//   timeout_flag_o              - sticky timeout indicator
//   busy_o                      - work pending or in progress
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [2:0]          cmd_op_i,
    input  logic [DATA_W-1:0]   cmd_a_i,
    input  logic [DATA_W-1:0]   cmd_b_i,
    output logic                alu_start_o,
    output logic [2:0]          alu_op_o,
    output logic [DATA_W-1:0]   alu_a_o,
    output logic [DATA_W-1:0]   alu_b_o,
    input  logic                alu_done_i,
    input  logic [2*DATA_W-1:0] alu_result_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [2:0]          rsp_op_o,
    output logic [2*DATA_W-1:0] rsp_result_o,
    output logic                rsp_err_o,
    output logic [31:0]         issued_cnt_o,
    output logic                timeout_flag_o,
    output logic                busy_o
);

    // The command struct depends on DATA_W, so it lives here rather than in the package
    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    localparam int CMD_W  = $bits(cmd_t);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    cmd_t             push_cmd;
    cmd_t             head_cmd;
    logic [CMD_W-1:0] head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_push;
    logic             fifo_pop;

    seq_state_e          state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                start_q, start_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [2*DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [31:0]         issued_q, issued_d;
    logic                timeout_flag_q, timeout_flag_d;

    // Ready is forced low while reset is held so nothing is accepted then
    assign cmd_ready_o = reset_i && !fifo_full;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign push_cmd    = '{op: cmd_op_i, a: cmd_a_i, b: cmd_b_i};
    assign head_cmd    = head_bits;

    alu_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (fifo_push),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .pop_data_o  (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign alu_start_o    = start_q;
    assign alu_op_o       = op_q;
    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_op_o       = op_q;
    assign rsp_result_o   = rsp_result_q;
    assign rsp_err_o      = rsp_err_q;
    assign issued_cnt_o   = issued_q;
    assign timeout_flag_o = timeout_flag_q;
    assign busy_o         = (state_q != ST_IDLE) || (fifo_count != '0);

    // Sequencer: pop in IDLE, hold start in ISSUE until done/timeout (NOP is a
    // single start pulse with no response), present the response in RESP.
    // The response opcode is op_q, which cannot change until the next pop.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        start_d        = start_q;
        wait_d         = wait_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_err_d      = rsp_err_q;
        rsp_result_d   = rsp_result_q;
        issued_d       = issued_q;
        timeout_flag_d = timeout_flag_q;
        fifo_pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_d     = head_cmd.op;
                    a_d      = head_cmd.a;
                    b_d      = head_cmd.b;
                    if (op_is_legal(head_cmd.op)) begin
                        start_d  = 1'b1;
                        issued_d = issued_q + 32'd1;
                        wait_d   = '0;
                        state_d  = ST_ISSUE;
                    end else begin
                        rsp_err_d    = 1'b1;
                        rsp_result_d = '0;
                        rsp_valid_d  = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                if (op_q == OP_NOP) begin
                    start_d = 1'b0;
                    state_d = ST_IDLE;
                end else if (alu_done_i) begin
                    start_d      = 1'b0;
                    rsp_result_d = alu_result_i;
                    rsp_err_d    = 1'b0;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_RESP;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    start_d        = 1'b0;
                    rsp_result_d   = '0;
                    rsp_err_d      = 1'b1;
                    rsp_valid_d    = 1'b1;
                    timeout_flag_d = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            start_q        <= 1'b0;
            wait_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_result_q   <= '0;
            issued_q       <= '0;
            timeout_flag_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            start_q        <= start_d;
            wait_q         <= wait_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_err_q      <= rsp_err_d;
            rsp_result_q   <= rsp_result_d;
            issued_q       <= issued_d;
            timeout_flag_q <= timeout_flag_d;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer (DATA_W=8, DEPTH=4, TIMEOUT=16). The
// bench plays the ALU side by hand, driving done/result at chosen cycles.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int DATA_W = 8;

    logic                clk_i;
    logic                reset_i;
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic [2:0]          cmd_op_i;
    logic [DATA_W-1:0]   cmd_a_i;
    logic [DATA_W-1:0]   cmd_b_i;
    logic                alu_start_o;
    logic [2:0]          alu_op_o;
    logic [DATA_W-1:0]   alu_a_o;
    logic [DATA_W-1:0]   alu_b_o;
    logic                alu_done_i;
    logic [2*DATA_W-1:0] alu_result_i;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [2:0]          rsp_op_o;
    logic [2*DATA_W-1:0] rsp_result_o;
    logic                rsp_err_o;
    logic [31:0]         issued_cnt_o;
    logic                timeout_flag_o;
    logic                busy_o;

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(
        .DATA_W  (DATA_W),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_a_i        (cmd_a_i),
        .cmd_b_i        (cmd_b_i),
        .alu_start_o    (alu_start_o),
        .alu_op_o       (alu_op_o),
        .alu_a_o        (alu_a_o),
        .alu_b_o        (alu_b_o),
        .alu_done_i     (alu_done_i),
        .alu_result_i   (alu_result_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_op_o       (rsp_op_o),
        .rsp_result_o   (rsp_result_o),
        .rsp_err_o      (rsp_err_o),
        .issued_cnt_o   (issued_cnt_o),
        .timeout_flag_o (timeout_flag_o),
        .busy_o         (busy_o)
    );

    // 10-time-unit clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Safety net in case the DUT stalls a step beyond every bounded loop
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=hang expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one edge and settle 1 unit past it for sampling and driving
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Offer one command for exactly one edge (caller knows ready is high)
    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_a_i     = a;
        cmd_b_i     = b;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    task automatic handshake(input string tag);
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checkOutput(tag, {31'd0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        int cnt;
        int guard;

        reset_i      = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_op_i     = '0;
        cmd_a_i      = '0;
        cmd_b_i      = '0;
        alu_done_i   = 1'b0;
        alu_result_i = '0;
        rsp_ready_i  = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rst_ready_low", {31'd0, cmd_ready_o}, 32'd0);
        checkOutput("rst_start", {31'd0, alu_start_o}, 32'd0);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("rst_issued", issued_cnt_o, 32'd0);
        reset_i = 1'b1;
        #1;
        checkOutput("rel_ready_high", {31'd0, cmd_ready_o}, 32'd1);
        checkOutput("rel_tflag", {31'd0, timeout_flag_o}, 32'd0);

        // ADD FF+01, done one cycle after start
        applyStimulus(3'd1, 8'hFF, 8'h01);
        checkOutput("add_start_before_pop", {31'd0, alu_start_o}, 32'd0);
        checkOutput("add_busy_queued", {31'd0, busy_o}, 32'd1);
        tick();
        checkOutput("add_start", {31'd0, alu_start_o}, 32'd1);
        checkOutput("add_alu_op", {29'd0, alu_op_o}, 32'd1);
        checkOutput("add_alu_a", {24'd0, alu_a_o}, 32'hFF);
        checkOutput("add_alu_b", {24'd0, alu_b_o}, 32'h01);
        checkOutput("add_issued", issued_cnt_o, 32'd1);
        alu_done_i   = 1'b1;
        alu_result_i = 16'h0100;
        tick();
        alu_done_i   = 1'b0;
        alu_result_i = 16'h0000;
        checkOutput("add_start_low", {31'd0, alu_start_o}, 32'd0);
        checkOutput("add_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        checkOutput("add_rsp_result", {16'd0, rsp_result_o}, 32'h0100);
        checkOutput("add_rsp_op", {29'd0, rsp_op_o}, 32'd1);
        checkOutput("add_rsp_err", {31'd0, rsp_err_o}, 32'd0);
        handshake("add_hs");
        checkOutput("add_idle_busy", {31'd0, busy_o}, 32'd0);

        // MUL 10*10, done three cycles after start, response held off 5 cycles
        applyStimulus(3'd4, 8'h10, 8'h10);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mul_start_high", {31'd0, alu_start_o}, 32'd1);
        end
        alu_done_i   = 1'b1;
        alu_result_i = 16'h0100;
        tick();
        alu_done_i   = 1'b0;
        alu_result_i = 16'hDEAD;
        checkOutput("mul_start_low", {31'd0, alu_start_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("mul_hold_valid", {31'd0, rsp_valid_o}, 32'd1);
            checkOutput("mul_hold_result", {16'd0, rsp_result_o}, 32'h0100);
            checkOutput("mul_hold_op", {29'd0, rsp_op_o}, 32'd4);
            tick();
        end
        handshake("mul_hs");
        checkOutput("mul_issued", issued_cnt_o, 32'd2);

        // NOP followed by XOR F0^3C; NOP pops on the same edge XOR is pushed
        applyStimulus(3'd0, 8'h00, 8'h00);
        applyStimulus(3'd3, 8'hF0, 8'h3C);
        checkOutput("nop_start", {31'd0, alu_start_o}, 32'd1);
        checkOutput("nop_alu_op", {29'd0, alu_op_o}, 32'd0);
        checkOutput("nop_issued", issued_cnt_o, 32'd3);
        tick();
        checkOutput("nop_start_one_cycle", {31'd0, alu_start_o}, 32'd0);
        checkOutput("nop_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        tick();
        checkOutput("xor_start", {31'd0, alu_start_o}, 32'd1);
        checkOutput("xor_alu_op", {29'd0, alu_op_o}, 32'd3);
        checkOutput("xor_alu_a", {24'd0, alu_a_o}, 32'hF0);
        alu_done_i   = 1'b1;
        alu_result_i = 16'h00CC;
        tick();
        alu_done_i   = 1'b0;
        checkOutput("xor_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        checkOutput("xor_rsp_result", {16'd0, rsp_result_o}, 32'h00CC);
        checkOutput("xor_rsp_op", {29'd0, rsp_op_o}, 32'd3);
        checkOutput("xor_issued", issued_cnt_o, 32'd4);
        handshake("xor_hs");

        // Illegal opcode 6: immediate error response, no start
        applyStimulus(3'd6, 8'h01, 8'h02);
        tick();
        checkOutput("ill_start", {31'd0, alu_start_o}, 32'd0);
        checkOutput("ill_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
        checkOutput("ill_rsp_err", {31'd0, rsp_err_o}, 32'd1);
        checkOutput("ill_rsp_result", {16'd0, rsp_result_o}, 32'h0000);
        checkOutput("ill_rsp_op", {29'd0, rsp_op_o}, 32'd6);
        checkOutput("ill_issued", issued_cnt_o, 32'd4);
        checkOutput("ill_tflag", {31'd0, timeout_flag_o}, 32'd0);
        handshake("ill_hs");

        // Backpressure: six ADDs offered back to back, no done ever returned.
        // Edge 1 pushes c1, edge 2 pops c1 and pushes c2, edges 3-5 fill the FIFO.
        cmd_valid_i = 1'b1;
        cmd_op_i    = 3'd1;
        cmd_b_i     = 8'h00;
        for (int i = 0; i < 5; i++) begin
            cmd_a_i = 8'(i + 1);
            checkOutput("bp_ready_before_push", {31'd0, cmd_ready_o}, 32'd1);
            tick();
        end
        cmd_a_i = 8'd6;
        checkOutput("bp_ready_full", {31'd0, cmd_ready_o}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            // c1 has already shown start on the samples after edges 2, 3 and 4
            cnt   = (k == 0) ? 3 : 0;
            guard = 0;
            while (!alu_start_o && guard < 10) begin
                tick();
                guard++;
            end
            while (alu_start_o && guard < 60) begin
                cnt++;
                if (k == 1 && cnt == 1) begin
                    checkOutput("bp_ready_after_pop", {31'd0, cmd_ready_o}, 32'd1);
                end
                if (k == 1 && cnt == 2) begin
                    cmd_valid_i = 1'b0;
                end
                tick();
                guard++;
            end
            checkOutput("bp_start_cycles", cnt, 32'd16);
            checkOutput("bp_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
            checkOutput("bp_rsp_err", {31'd0, rsp_err_o}, 32'd1);
            checkOutput("bp_rsp_result", {16'd0, rsp_result_o}, 32'h0000);
            checkOutput("bp_order_a", {24'd0, alu_a_o}, 32'(k + 1));
            checkOutput("bp_tflag", {31'd0, timeout_flag_o}, 32'd1);
            handshake("bp_hs");
        end
        checkOutput("bp_issued", issued_cnt_o, 32'd10);
        checkOutput("bp_drained_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("bp_drained_ready", {31'd0, cmd_ready_o}, 32'd1);

        // Reset two cycles into a MUL with two ADDs queued behind it
        applyStimulus(3'd4, 8'h02, 8'h03);
        applyStimulus(3'd1, 8'h11, 8'h22);
        applyStimulus(3'd1, 8'h33, 8'h44);
        checkOutput("mr_start_before", {31'd0, alu_start_o}, 32'd1);
        checkOutput("mr_issued_before", issued_cnt_o, 32'd11);
        reset_i = 1'b0;
        tick();
        checkOutput("mr_start", {31'd0, alu_start_o}, 32'd0);
        checkOutput("mr_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        checkOutput("mr_busy", {31'd0, busy_o}, 32'd0);
        checkOutput("mr_issued", issued_cnt_o, 32'd0);
        checkOutput("mr_tflag", {31'd0, timeout_flag_o}, 32'd0);
        checkOutput("mr_alu_op", {29'd0, alu_op_o}, 32'd0);
        checkOutput("mr_ready_in_reset", {31'd0, cmd_ready_o}, 32'd0);
        reset_i      = 1'b1;
        alu_done_i   = 1'b1;
        alu_result_i = 16'hBEEF;
        #1;
        checkOutput("mr_ready_released", {31'd0, cmd_ready_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("mr_late_done_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
            checkOutput("mr_late_done_no_start", {31'd0, alu_start_o}, 32'd0);
        end
        alu_done_i = 1'b0;
        checkOutput("mr_final_busy", {31'd0, busy_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
